// File: rtl/sram_pkg.sv
// Shared definitions for the asynchronous SRAM controller.
//   state_e    : controller FSM states
//   DefWaitRd  : default read access length (cycles with OE_n low)
//   DefWaitWr  : default write pulse length (cycles with WE_n low)
//   cnt_width(): bits needed by the wait counter to hold max_val-1
package sram_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWrSetup,
    StWrPulse,
    StWrHold
  } state_e;

  localparam int unsigned DefWaitRd = 2;
  localparam int unsigned DefWaitWr = 2;

  // The counter is loaded with (wait - 1), so it must represent max_val - 1.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? unsigned'($clog2(max_val)) : 1;
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter with a done flag, used to time SRAM access phases.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : load load_val_i (has priority over dec_i)
//   load_val_i    : value to load (phase length minus one)
//   dec_i         : decrement by one; saturates at zero
//   done_o        : counter is zero, i.e. the current cycle is the last one of the phase
module sram_wait_cnt #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller with fully registered pad outputs.
//   iClk, iRst_n        : clock, asynchronous active-low reset
//   iReq/iWe/iAddr/iWData : CPU request (level, held until oAck), sampled at accept
//   oAck                : one-cycle completion pulse
//   oBusy               : transaction in progress
//   oRData              : data of the most recent completed read
//   oSramA/oSramD/oSramDOe : SRAM address, write data, data pad output enable
//   iSramD              : SRAM read data from the pad
//   oSramCe_n/oSramOe_n/oSramWe_n : active-low SRAM strobes
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned WAIT_RD = DefWaitRd,
  parameter int unsigned WAIT_WR = DefWaitWr
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iReq,
  input  logic              iWe,
  input  logic [19:0]       iAddr,
  input  logic [7:0]        iWData,
  output logic              oAck,
  output logic              oBusy,
  output logic [7:0]        oRData,
  output logic [ADDR_W-1:0] oSramA,
  output logic [7:0]        oSramD,
  output logic              oSramDOe,
  input  logic [7:0]        iSramD,
  output logic              oSramCe_n,
  output logic              oSramOe_n,
  output logic              oSramWe_n
);

  localparam int unsigned MaxWait = (WAIT_RD > WAIT_WR) ? WAIT_RD : WAIT_WR;
  localparam int unsigned CntW    = cnt_width(MaxWait);
  localparam logic [CntW-1:0] RdLoad = CntW'(WAIT_RD - 1);
  localparam logic [CntW-1:0] WrLoad = CntW'(WAIT_WR - 1);

  state_e            state_q, state_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              doe_q, doe_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;

  logic            cnt_load;
  logic [CntW-1:0] cnt_val;
  logic            cnt_dec;
  logic            cnt_done;

  // Upper CPU address bits lie outside the SRAM and are dropped.
  if (ADDR_W < 20) begin : g_addr_trunc
    logic unused_addr_hi;
    assign unused_addr_hi = ^iAddr[19:ADDR_W];
  end

  sram_wait_cnt #(
    .Width (CntW)
  ) u_wait_cnt (
    .clk_i      (iClk),
    .rst_ni     (iRst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .done_o     (cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // The ack cycle blocks a new accept, which also gives the bus a turnaround cycle.
        if (iReq && !ack_q) begin
          addr_d  = iAddr[ADDR_W-1:0];
          wdata_d = iWData;
          if (iWe) begin
            state_d = StWrSetup;
          end else begin
            state_d  = StRd;
            cnt_load = 1'b1;
            cnt_val  = RdLoad;
          end
        end
      end
      StRd: begin
        if (cnt_done) begin
          state_d = StIdle;
          ack_d   = 1'b1;
          rdata_d = iSramD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StWrSetup: begin
        state_d  = StWrPulse;
        cnt_load = 1'b1;
        cnt_val  = WrLoad;
      end
      StWrPulse: begin
        if (cnt_done) begin
          state_d = StWrHold;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StWrHold: begin
        state_d = StIdle;
        ack_d   = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Strobes are decoded from the next state so the pads are glitch-free registers.
    busy_d = (state_d != StIdle);
    ce_n_d = (state_d == StIdle);
    oe_n_d = (state_d != StRd);
    we_n_d = (state_d != StWrPulse);
    doe_d  = (state_d == StWrSetup) || (state_d == StWrPulse) || (state_d == StWrHold);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      doe_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      doe_q   <= doe_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign oAck      = ack_q;
  assign oBusy     = busy_q;
  assign oRData    = rdata_q;
  assign oSramA    = addr_q;
  assign oSramD    = wdata_q;
  assign oSramDOe  = doe_q;
  assign oSramCe_n = ce_n_q;
  assign oSramOe_n = oe_n_q;
  assign oSramWe_n = we_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: a transaction-level timing model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sram_ctrl;

  localparam int unsigned ADDR_W  = 18;
  localparam int unsigned WAIT_RD = 2;
  localparam int unsigned WAIT_WR = 2;

  logic              iClk   = 1'b0;
  logic              iRst_n = 1'b0;
  logic              iReq   = 1'b0;
  logic              iWe    = 1'b0;
  logic [19:0]       iAddr  = '0;
  logic [7:0]        iWData = '0;
  logic [7:0]        iSramD = '0;
  logic              oAck, oBusy, oSramDOe, oSramCe_n, oSramOe_n, oSramWe_n;
  logic [7:0]        oRData, oSramD;
  logic [ADDR_W-1:0] oSramA;

  int   checks  = 0;
  int   errors  = 0;
  int   overlap = 0;
  logic chk_en  = 1'b0;

  always #5 iClk = ~iClk;

  sram_ctrl #(
    .ADDR_W  (ADDR_W),
    .WAIT_RD (WAIT_RD),
    .WAIT_WR (WAIT_WR)
  ) dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iReq      (iReq),
    .iWe       (iWe),
    .iAddr     (iAddr),
    .iWData    (iWData),
    .oAck      (oAck),
    .oBusy     (oBusy),
    .oRData    (oRData),
    .oSramA    (oSramA),
    .oSramD    (oSramD),
    .oSramDOe  (oSramDOe),
    .iSramD    (iSramD),
    .oSramCe_n (oSramCe_n),
    .oSramOe_n (oSramOe_n),
    .oSramWe_n (oSramWe_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: a transaction is alive for a fixed number of edges after its accept
  // edge (m_t counts edges since accept); strobes follow from its kind and age.
  bit                m_active = 1'b0;
  bit                m_wr     = 1'b0;
  bit                m_ack    = 1'b0;
  int                m_t      = 0;
  logic [ADDR_W-1:0] m_addr   = '0;
  logic [7:0]        m_wdata  = '0;
  logic [7:0]        m_rdata  = '0;

  always @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      m_active <= 1'b0;
      m_wr     <= 1'b0;
      m_ack    <= 1'b0;
      m_t      <= 0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_rdata  <= '0;
    end else begin
      m_ack <= 1'b0;
      if (m_active) begin
        if (m_t + 1 == (m_wr ? int'(WAIT_WR) + 2 : int'(WAIT_RD))) begin
          m_active <= 1'b0;
          m_ack    <= 1'b1;
          if (!m_wr) m_rdata <= iSramD;
        end
        m_t <= m_t + 1;
      end else if (iReq && !m_ack) begin
        m_active <= 1'b1;
        m_t      <= 0;
        m_wr     <= iWe;
        m_addr   <= ADDR_W'(int'(iAddr) % (1 << ADDR_W));
        m_wdata  <= iWData;
      end
    end
  end

  always @(negedge iClk) begin
    if (chk_en) begin
      check("cyc_ack", oAck, m_ack);
      check("cyc_busy", oBusy, m_active);
      check("cyc_ce_n", oSramCe_n, !m_active);
      check("cyc_oe_n", oSramOe_n, !(m_active && !m_wr));
      check("cyc_we_n", oSramWe_n,
            !(m_active && m_wr && m_t >= 1 && m_t <= int'(WAIT_WR)));
      check("cyc_doe", oSramDOe, m_active && m_wr);
      check("cyc_addr", oSramA, m_addr);
      check("cyc_sram_d", oSramD, m_wdata);
      check("cyc_rdata", oRData, m_rdata);
      if (!oSramWe_n && !oSramOe_n) overlap++;
    end
  end

  typedef struct {
    int                acc_k;
    int                ack_k;
    int                oe_low;
    int                we_low;
    int                doe_hi;
    int                bad_d;
    logic              ack_doe;
    logic              ack_oe_n;
    logic [ADDR_W-1:0] addr;
  } txn_res_t;

  // Issues one request at posedge+1 and samples every cycle until oAck (bounded).
  task automatic run_txn(input logic we, input logic [19:0] addr, input logic [7:0] wd,
                         input logic [7:0] sd, output txn_res_t r);
    r = '{acc_k: -1, ack_k: -1, oe_low: 0, we_low: 0, doe_hi: 0, bad_d: 0,
          ack_doe: 1'b1, ack_oe_n: 1'b0, addr: '0};
    iWe = we; iAddr = addr; iWData = wd; iSramD = sd; iReq = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge iClk); #1;
      if (oBusy && r.acc_k < 0) begin
        r.acc_k = k;
        r.addr  = oSramA;
      end
      if (!oSramOe_n) r.oe_low++;
      if (!oSramWe_n) r.we_low++;
      if (oSramDOe) begin
        r.doe_hi++;
        if (oSramD !== wd) r.bad_d++;
      end
      if (oAck) begin
        r.ack_k    = k;
        r.ack_doe  = oSramDOe;
        r.ack_oe_n = oSramOe_n;
        break;
      end
    end
    iReq = 1'b0;
  endtask

  txn_res_t r, rw;
  int       acks, last_ack, min_gap, max_gap;

  initial begin
    iRst_n = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    chk_en = 1'b1;
    check("rst_ack", oAck, 0);
    check("rst_busy", oBusy, 0);
    check("rst_ce_n", oSramCe_n, 1);
    check("rst_oe_n", oSramOe_n, 1);
    check("rst_we_n", oSramWe_n, 1);
    check("rst_doe", oSramDOe, 0);
    check("rst_addr", oSramA, 0);
    check("rst_sram_d", oSramD, 0);
    check("rst_rdata", oRData, 0);
    iRst_n = 1'b1;
    @(posedge iClk); #1;

    // Read 0x00100 returning 0xA5.
    run_txn(1'b0, 20'h00100, 8'h00, 8'hA5, r);
    check("rd_latency", r.ack_k - r.acc_k, 2);
    check("rd_oe_low", r.oe_low, 2);
    check("rd_we_low", r.we_low, 0);
    check("rd_doe", r.doe_hi, 0);
    check("rd_addr", r.addr, 18'h00100);
    check("rd_data", oRData, 8'hA5);

    // Write 0x5A to 0x3FFFF.
    run_txn(1'b1, 20'h3FFFF, 8'h5A, 8'h00, r);
    check("wr_latency", r.ack_k - r.acc_k, 4);
    check("wr_we_low", r.we_low, 2);
    check("wr_doe_hi", r.doe_hi, 4);
    check("wr_data_stable", r.bad_d, 0);
    check("wr_oe_low", r.oe_low, 0);
    check("wr_addr", r.addr, 18'h3FFFF);
    check("wr_ack_doe", r.ack_doe, 0);
    check("rdata_held", oRData, 8'hA5);

    // Upper address bits dropped.
    run_txn(1'b0, 20'hC1234, 8'h00, 8'h3C, r);
    check("trunc_addr", r.addr, 18'h01234);
    check("trunc_data", oRData, 8'h3C);

    // Write immediately followed by a read: the ack cycle is skipped, giving turnaround.
    run_txn(1'b1, 20'h00200, 8'h81, 8'h00, rw);
    run_txn(1'b0, 20'h00200, 8'h00, 8'h81, r);
    check("ta_ack_doe", rw.ack_doe, 0);
    check("ta_ack_oe_n", rw.ack_oe_n, 1);
    check("ta_rd_accept", r.acc_k, 1);
    check("ta_rd_latency", r.ack_k - r.acc_k, 2);
    check("ta_rd_data", oRData, 8'h81);

    // iReq held across three reads: acks WAIT_RD+2 edges apart.
    acks = 0; last_ack = -1; min_gap = 1000; max_gap = 0;
    iWe = 1'b0; iAddr = 20'h00010; iSramD = 8'h11; iReq = 1'b1;
    for (int k = 0; k < 40 && acks < 3; k++) begin
      @(posedge iClk); #1;
      if (oAck) begin
        acks++;
        if (last_ack >= 0) begin
          if (k - last_ack - 1 < min_gap) min_gap = k - last_ack - 1;
          if (k - last_ack - 1 > max_gap) max_gap = k - last_ack - 1;
        end
        last_ack = k;
        iSramD = iSramD + 8'h11;
        if (acks == 3) iReq = 1'b0;
      end
    end
    iReq = 1'b0;
    check("held_acks", acks, 3);
    check("held_min_gap", min_gap, 3);
    check("held_max_gap", max_gap, 3);
    check("held_last_data", oRData, 8'h33);
    repeat (6) begin
      @(posedge iClk); #1;
      if (oAck) acks++;
    end
    check("held_no_extra_ack", acks, 3);

    // Reset asserted during the write pulse.
    iWe = 1'b1; iAddr = 20'h00042; iWData = 8'h77; iReq = 1'b1;
    @(posedge iClk); #1;
    check("abort_setup_busy", oBusy, 1);
    @(posedge iClk); #1;
    check("abort_pulse_we_n", oSramWe_n, 0);
    #2;
    iRst_n = 1'b0; iReq = 1'b0;
    #1;
    check("abort_we_n", oSramWe_n, 1);
    check("abort_doe", oSramDOe, 0);
    check("abort_busy", oBusy, 0);
    check("abort_addr", oSramA, 0);
    repeat (2) @(posedge iClk);
    #1;
    iRst_n = 1'b1;
    acks = 0;
    repeat (6) begin
      @(posedge iClk); #1;
      if (oAck) acks++;
    end
    check("abort_no_ack", acks, 0);

    // Request pending at reset release is accepted on the first edge.
    #2;
    iRst_n = 1'b0;
    @(posedge iClk); #1;
    iRst_n = 1'b1;
    run_txn(1'b0, 20'h00ABC, 8'h00, 8'hE7, r);
    check("post_rst_accept", r.acc_k, 0);
    check("post_rst_latency", r.ack_k - r.acc_k, 2);
    check("post_rst_data", oRData, 8'hE7);

    repeat (3) @(posedge iClk);
    #1;
    check("we_oe_overlap", overlap, 0);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, external SRAM address width.
REQ-002 SHALL have parameter WAIT_RD, default 2, read access cycles with OE_n low; minimum 1.
REQ-003 SHALL have parameter WAIT_WR, default 2, write-pulse cycles with WE_n low; minimum 1.
REQ-004 SHALL have port iClk  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port iRst_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port iReq  in  1  CPU request, level, held until oAck.
REQ-007 SHALL have port iWe  in  1  1 = write, 0 = read; sampled at accept.
REQ-008 SHALL have port iAddr  in  20  CPU byte address.
REQ-009 SHALL have port iWData  in  8  write data; sampled at accept.
REQ-010 SHALL have port oAck  out  1  one-cycle completion pulse.
REQ-011 SHALL have port oBusy  out  1  transaction in progress.
REQ-012 SHALL have port oRData  out  8  last read data; held until the next read completes.
REQ-013 SHALL have port oSramA  out  ADDR_W  SRAM address.
REQ-014 SHALL have port oSramD  out  8  SRAM write data.
REQ-015 SHALL have port oSramDOe  out  1  SRAM data pad output enable.
REQ-016 SHALL have port iSramD  in  8  SRAM read data from pad.
REQ-017 SHALL have ports oSramCe_n, oSramOe_n, oSramWe_n  out  1 each  SRAM strobes, active-low.

Function
REQ-018 SHALL implement FSM states IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD; all outputs registered.
REQ-019 SHALL accept a request only in IDLE with iReq=1 and oAck=0, latching iAddr[ADDR_W-1:0], iWData and iWe; upper address bits are discarded.
REQ-020 SHALL ignore iReq in the oAck cycle; the earliest next accept is the following edge.
REQ-021 SHALL, on a read, enter RD for WAIT_RD cycles with Ce_n=0, Oe_n=0, We_n=1 and DOe=0.
REQ-022 SHALL, on the final RD edge, capture iSramD into oRData, pulse oAck, and return to IDLE; oAck appears WAIT_RD cycles after the accept edge.
REQ-023 SHALL, on a write, run WR_SETUP (1 cycle, We_n=1), WR_PULSE (WAIT_WR cycles, We_n=0), then WR_HOLD (1 cycle, We_n=1).
REQ-024 SHALL, throughout the write phases, drive Ce_n=0, Oe_n=1 and DOe=1, and keep oSramA and oSramD stable.
REQ-025 SHALL, on the final WR_HOLD edge, pulse oAck, return to IDLE and drop DOe; oAck appears WAIT_WR+2 cycles after the accept edge.
REQ-026 SHALL, in IDLE, drive Ce_n=1, Oe_n=1, We_n=1 and DOe=0, with oSramA holding its last value.
REQ-027 SHALL guarantee at least one cycle with DOe=0 and Oe_n=1 between a write and a following read (bus turnaround), satisfied through REQ-020.
REQ-028 SHALL assert oBusy in every non-IDLE state; oBusy=0 in the oAck cycle.
REQ-029 SHALL never drive We_n=0 and Oe_n=0 in the same cycle.

Reset
REQ-030 SHALL, on iRst_n=0, immediately force state IDLE, oAck=0, oBusy=0, We_n=1, Oe_n=1, Ce_n=1, DOe=0, oSramA=0, oSramD=0 and oRData=0.
REQ-031 SHALL abort a transaction that is in flight when reset asserts, with no oAck after reset release.
REQ-032 SHALL accept requests from the first edge after iRst_n deasserts.

Structure
REQ-033 SHALL place the state enum and the default WAIT_RD/WAIT_WR constants in shared package sram_pkg.
REQ-034 SHALL use one sub-module, sram_wait_cnt: a loadable down-counter with a done flag, shared by RD and WR_PULSE.

Verification
REQ-035 SHALL cover a read at 0x00100 with iSramD=0xA5, WAIT_RD=2 -> Oe_n low 2 cycles, oAck 2 cycles after accept, oRData=0xA5.
REQ-036 SHALL cover a write of 0x5A to 0x3FFFF -> We_n low exactly 2 cycles, oSramD=0x5A and DOe=1 from setup through hold, oAck at cycle 4.
REQ-037 SHALL cover iAddr=0xC1234 -> oSramA=0x01234.
REQ-038 SHALL cover a write immediately followed by a read -> at least one cycle with DOe=0 and Oe_n=1 between them, never We_n=Oe_n=0.
REQ-039 SHALL cover iRst_n dropping during WR_PULSE -> We_n=1 and DOe=0 without a clock edge, no oAck after release.
REQ-040 SHALL cover iReq held high across 3 reads -> exactly 3 oAck pulses, each separated by at least one non-ack IDLE cycle.
